// File: rtl/tt_um_jleugeri_ttt_event_scheduler.sv
// Event scheduler for the token network.
// Each go_in pulse snapshots the start/stop flags and scans processors in ascending order.
// For each processor with a net event, it looks up that processor's connection range.
// It then streams one signed delta per connection over a valid/ready handshake.
module tt_um_jleugeri_ttt_event_scheduler #(
  parameter int unsigned NUM_PROCESSORS = 10,
  parameter int unsigned IDX_BITS       = $clog2(NUM_PROCESSORS),
  parameter int unsigned CONN_BITS      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        go_in,
  output logic                        busy_out,
  output logic                        done_out,
  input  logic [2*NUM_PROCESSORS-1:0] tstartstop_in,
  output logic                        range_req_out,
  output logic [IDX_BITS-1:0]         src_idx_out,
  input  logic [CONN_BITS-1:0]        range_first_in,
  input  logic [CONN_BITS-1:0]        range_last_in,
  output logic                        tgt_valid_out,
  input  logic                        tgt_ready_in,
  output logic [CONN_BITS-1:0]        conn_addr_out,
  output logic                        tgt_sign_out
);

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StFetch,
    StWait,
    StDeliver,
    StDone
  } state_e;

  localparam logic [IDX_BITS-1:0] LastIdx = IDX_BITS'(NUM_PROCESSORS - 1);

  state_e                        state_q, state_d;
  logic [2*NUM_PROCESSORS-1:0]   pend_q, pend_d;
  logic [IDX_BITS-1:0]           idx_q, idx_d;
  logic                          sign_q, sign_d;
  logic [CONN_BITS-1:0]          conn_q, conn_d;
  logic [CONN_BITS-1:0]          last_q, last_d;
  logic                          busy_q, done_q, req_q, valid_q;

  logic [NUM_PROCESSORS-1:0]     start_vec, stop_vec;
  logic                          cur_start, cur_event, at_last_idx;
  state_e                        adv_state;
  logic [IDX_BITS-1:0]           adv_idx;

  // Split the pending snapshot into per-processor start and stop vectors.
  always_comb begin
    start_vec = '0;
    stop_vec  = '0;
    for (int i = 0; i < int'(NUM_PROCESSORS); i++) begin
      start_vec[i] = pend_q[2*i];
      stop_vec[i]  = pend_q[2*i+1];
    end
  end

  assign cur_start   = start_vec[idx_q];
  // A start together with a stop cancels out, so only XOR counts as a net event.
  assign cur_event   = start_vec[idx_q] ^ stop_vec[idx_q];
  assign at_last_idx = (idx_q == LastIdx);

  // Advance to the next source, or finish the sweep after the last processor.
  always_comb begin
    adv_idx   = idx_q;
    adv_state = StDone;
    if (!at_last_idx) begin
      adv_idx   = idx_q + IDX_BITS'(1);
      adv_state = StScan;
    end
  end

  // Next-state and datapath update for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    sign_d  = sign_q;
    conn_d  = conn_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (go_in) begin
          pend_d  = tstartstop_in;
          idx_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (cur_event) begin
          state_d = StFetch;
        end else begin
          state_d = adv_state;
          idx_d   = adv_idx;
        end
      end
      StFetch: begin
        sign_d  = cur_start;
        state_d = StWait;
      end
      StWait: begin
        if (range_first_in > range_last_in) begin
          state_d = adv_state;
          idx_d   = adv_idx;
        end else begin
          conn_d  = range_first_in;
          last_d  = range_last_in;
          state_d = StDeliver;
        end
      end
      StDeliver: begin
        if (tgt_ready_in) begin
          // Compare before incrementing so a range ending at the top address never wraps.
          if (conn_q == last_q) begin
            state_d = adv_state;
            idx_d   = adv_idx;
          end else begin
            conn_d = conn_q + CONN_BITS'(1);
          end
        end
      end
      StDone: begin
        idx_d   = '0;
        state_d = StIdle;
      end
      default: begin
        idx_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State registers, with the strobes registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pend_q  <= '0;
      idx_q   <= '0;
      sign_q  <= 1'b0;
      conn_q  <= '0;
      last_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      sign_q  <= sign_d;
      conn_q  <= conn_d;
      last_q  <= last_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
      req_q   <= (state_d == StFetch);
      valid_q <= (state_d == StDeliver);
    end
  end

  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign range_req_out = req_q;
  assign tgt_valid_out = valid_q;
  // The index is cleared on the way back to idle, so it reads 0 there.
  assign src_idx_out   = idx_q;
  assign conn_addr_out = conn_q;
  assign tgt_sign_out  = sign_q;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_event_scheduler.sv
// Self-checking bench for the event scheduler.
// Directed vectors, hand-written corner sequences and randomized sweeps are checked.
// Every sweep is checked against a sweep-level reference model.
module tb_tt_um_jleugeri_ttt_event_scheduler;

  localparam int N   = 10;
  localparam int IB  = 4;
  localparam int CB  = 8;
  localparam int NV  = 7;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            go_in;
  logic            busy_out, done_out, range_req_out, tgt_valid_out, tgt_sign_out;
  logic [2*N-1:0]  tstartstop_in;
  logic [IB-1:0]   src_idx_out;
  logic [CB-1:0]   range_first_in, range_last_in, conn_addr_out;
  logic            tgt_ready_in;

  tt_um_jleugeri_ttt_event_scheduler #(
    .NUM_PROCESSORS(N),
    .IDX_BITS(IB),
    .CONN_BITS(CB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .go_in(go_in),
    .busy_out(busy_out),
    .done_out(done_out),
    .tstartstop_in(tstartstop_in),
    .range_req_out(range_req_out),
    .src_idx_out(src_idx_out),
    .range_first_in(range_first_in),
    .range_last_in(range_last_in),
    .tgt_valid_out(tgt_valid_out),
    .tgt_ready_in(tgt_ready_in),
    .conn_addr_out(conn_addr_out),
    .tgt_sign_out(tgt_sign_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Connection table: data is presented only in the cycle after a lookup strobe.
  logic [CB-1:0] tbl_first [N];
  logic [CB-1:0] tbl_last  [N];
  logic          req_d1 = 1'b0;
  always @(posedge clk) req_d1 <= range_req_out;
  assign range_first_in = req_d1 ? tbl_first[src_idx_out] : 8'hA5;
  assign range_last_in  = req_d1 ? tbl_last[src_idx_out]  : 8'h5A;

  // Ready modes: 0 always 1, 1 toggle 1-0-1, 2 random, 3 always 0.
  int rmode = 0;
  always @(negedge clk) begin
    case (rmode)
      0: tgt_ready_in = 1'b1;
      1: tgt_ready_in = ~tgt_ready_in;
      2: tgt_ready_in = ($urandom_range(0, 9) < 7);
      default: tgt_ready_in = 1'b0;
    endcase
  end

  // Monitor: observes what the DUT presents to the upcoming rising edge.
  int got_req[$];
  int got_delta[$];
  int exp_req[$];
  int exp_delta[$];
  int busy_cnt = 0;
  int done_seen = 0;
  bit prev_stall = 0;
  int prev_vals = 0;

  function automatic int enc(input int src, input int conn, input int sign);
    return src * 512 + conn * 2 + sign;
  endfunction

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (range_req_out) got_req.push_back(int'(src_idx_out));
      if (tgt_valid_out && tgt_ready_in)
        got_delta.push_back(enc(int'(src_idx_out), int'(conn_addr_out), int'(tgt_sign_out)));
      if (prev_stall)
        chk("stall_hold", (int'(tgt_valid_out) << 20) |
            enc(int'(src_idx_out), int'(conn_addr_out), int'(tgt_sign_out)), prev_vals);
      prev_stall = tgt_valid_out && !tgt_ready_in;
      prev_vals  = (1 << 20) | enc(int'(src_idx_out), int'(conn_addr_out), int'(tgt_sign_out));
      chk("strobe_exclusive", int'($onehot0({range_req_out, tgt_valid_out, done_out})), 1);
      if (busy_out) busy_cnt++;
      if (done_out) done_seen++;
    end
  end

  // Reference model: the sweep as an ordered list of lookups and deltas.
  task automatic compute_expected(input logic [2*N-1:0] tss);
    exp_req.delete();
    exp_delta.delete();
    for (int i = 0; i < N; i++) begin
      int s, p;
      s = int'(tss[2*i]);
      p = int'(tss[2*i+1]);
      if (s != p) begin
        exp_req.push_back(i);
        for (int a = int'(tbl_first[i]); a <= int'(tbl_last[i]); a++)
          exp_delta.push_back(enc(i, a, s));
      end
    end
  endtask

  task automatic compare_sweep();
    chk("lookup_count", got_req.size(), exp_req.size());
    for (int i = 0; i < exp_req.size() && i < got_req.size(); i++)
      chk("lookup_src", got_req[i], exp_req[i]);
    chk("delta_count", got_delta.size(), exp_delta.size());
    for (int i = 0; i < exp_delta.size() && i < got_delta.size(); i++)
      chk("delta", got_delta[i], exp_delta[i]);
    chk("done_pulses", done_seen, 1);
  endtask

  task automatic start_sweep(input logic [2*N-1:0] tss);
    got_req.delete();
    got_delta.delete();
    busy_cnt  = 0;
    done_seen = 0;
    tstartstop_in = tss;
    @(negedge clk);
    go_in = 1'b1;
    @(negedge clk);
    go_in = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int n;
    n = 0;
    while (done_seen == 0 && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (done_seen == 0) chk("done_timeout", 0, 1);
    lat = n;
  endtask

  task automatic post_idle();
    @(negedge clk);
    #2;
    chk("idle_busy", int'(busy_out), 0);
    chk("idle_src", int'(src_idx_out), 0);
  endtask

  typedef struct {
    logic [2*N-1:0]        tss;
    logic [N-1:0][CB-1:0]  first;
    logic [N-1:0][CB-1:0]  last;
    int                    exp_reqs;
    int                    exp_deltas;
    int                    exp_busy;
  } vec_t;

  vec_t vecs[NV];

  task automatic load_vec(input int v);
    for (int i = 0; i < N; i++) begin
      tbl_first[i] = vecs[v].first[i];
      tbl_last[i]  = vecs[v].last[i];
    end
  endtask

  initial begin
    int lat;
    logic [2*N-1:0] snap;

    for (int v = 0; v < NV; v++) begin
      vecs[v].tss   = '0;
      vecs[v].first = '0;
      vecs[v].last  = '0;
    end
    // 0: no events
    vecs[0].exp_reqs = 0; vecs[0].exp_deltas = 0; vecs[0].exp_busy = 11;
    // 1: processor 3 start, range 5..7
    vecs[1].tss[6] = 1'b1; vecs[1].first[3] = 8'd5; vecs[1].last[3] = 8'd7;
    vecs[1].exp_reqs = 1; vecs[1].exp_deltas = 3; vecs[1].exp_busy = 16;
    // 2: processor 0 stop (0..1), processor 9 start (10..12)
    vecs[2].tss[1] = 1'b1; vecs[2].tss[18] = 1'b1;
    vecs[2].first[0] = 8'd0;  vecs[2].last[0] = 8'd1;
    vecs[2].first[9] = 8'd10; vecs[2].last[9] = 8'd12;
    vecs[2].exp_reqs = 2; vecs[2].exp_deltas = 5; vecs[2].exp_busy = 20;
    // 3: processor 4 start+stop, processor 6 empty range 8..2
    vecs[3].tss[8] = 1'b1; vecs[3].tss[9] = 1'b1; vecs[3].tss[12] = 1'b1;
    vecs[3].first[4] = 8'd1; vecs[3].last[4] = 8'd3;
    vecs[3].first[6] = 8'd8; vecs[3].last[6] = 8'd2;
    vecs[3].exp_reqs = 1; vecs[3].exp_deltas = 0; vecs[3].exp_busy = 13;
    // 4: processor 2 start, range 254..255
    vecs[4].tss[4] = 1'b1; vecs[4].first[2] = 8'd254; vecs[4].last[2] = 8'd255;
    vecs[4].exp_reqs = 1; vecs[4].exp_deltas = 2; vecs[4].exp_busy = 15;
    // 5: every processor starts, range i..i
    for (int i = 0; i < N; i++) begin
      vecs[5].tss[2*i] = 1'b1;
      vecs[5].first[i] = CB'(i);
      vecs[5].last[i]  = CB'(i);
    end
    vecs[5].exp_reqs = 10; vecs[5].exp_deltas = 10; vecs[5].exp_busy = 41;
    // 6: last processor stop, range 255..255
    vecs[6].tss[19] = 1'b1; vecs[6].first[9] = 8'd255; vecs[6].last[9] = 8'd255;
    vecs[6].exp_reqs = 1; vecs[6].exp_deltas = 1; vecs[6].exp_busy = 14;

    rst_n = 1'b0;
    go_in = 1'b0;
    tstartstop_in = '0;
    tgt_ready_in = 1'b1;
    for (int i = 0; i < N; i++) begin
      tbl_first[i] = '0;
      tbl_last[i]  = '0;
    end
    #23;
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_done", int'(done_out), 0);
    chk("rst_req", int'(range_req_out), 0);
    chk("rst_valid", int'(tgt_valid_out), 0);
    chk("rst_src", int'(src_idx_out), 0);
    chk("rst_conn", int'(conn_addr_out), 0);
    chk("rst_sign", int'(tgt_sign_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with ready held high.
    for (int v = 0; v < NV; v++) begin
      load_vec(v);
      rmode = 0;
      compute_expected(vecs[v].tss);
      start_sweep(vecs[v].tss);
      wait_done(lat);
      compare_sweep();
      chk("vec_reqs", got_req.size(), vecs[v].exp_reqs);
      chk("vec_deltas", got_delta.size(), vecs[v].exp_deltas);
      chk("vec_busy_cycles", busy_cnt, vecs[v].exp_busy);
      chk("vec_done_latency", lat, vecs[v].exp_busy - 1);
      post_idle();
    end

    // Ready toggling 1-0-1 on the mixed-sign vector.
    load_vec(2);
    rmode = 1;
    compute_expected(vecs[2].tss);
    start_sweep(vecs[2].tss);
    wait_done(lat);
    compare_sweep();
    post_idle();

    // Input changes and a go pulse mid-sweep are ignored.
    load_vec(4);
    rmode = 0;
    snap = vecs[4].tss;
    compute_expected(snap);
    start_sweep(snap);
    @(negedge clk);
    tstartstop_in = 20'hAAAAA;
    go_in = 1'b1;
    @(negedge clk);
    go_in = 1'b0;
    tstartstop_in = 20'h55555;
    wait_done(lat);
    compare_sweep();
    repeat (3) @(negedge clk);
    #2;
    chk("no_restart_busy", int'(busy_out), 0);

    // Reset while a delta is stalled in delivery.
    load_vec(1);
    rmode = 3;
    start_sweep(vecs[1].tss);
    lat = 0;
    while (!tgt_valid_out && lat < 100) begin
      @(negedge clk);
      #2;
      lat++;
    end
    chk("reached_deliver", int'(tgt_valid_out), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy_out), 0);
    chk("midrst_valid", int'(tgt_valid_out), 0);
    chk("midrst_conn", int'(conn_addr_out), 0);
    chk("midrst_src", int'(src_idx_out), 0);
    chk("midrst_sign", int'(tgt_sign_out), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("midrst_no_done", done_seen, 0);
    rmode = 0;
    compute_expected(vecs[1].tss);
    start_sweep(vecs[1].tss);
    wait_done(lat);
    compare_sweep();
    chk("after_rst_busy_cycles", busy_cnt, 16);
    post_idle();

    // Randomized sweeps with random ranges and back-pressure.
    for (int it = 0; it < 25; it++) begin
      logic [2*N-1:0] tss;
      tss = '0;
      for (int i = 0; i < N; i++) begin
        int f, l;
        tss[2*i]   = 1'($urandom_range(0, 1));
        tss[2*i+1] = 1'($urandom_range(0, 1));
        f = (($urandom_range(0, 3) == 0) ? 250 : 0) + $urandom_range(0, 5);
        if ($urandom_range(0, 6) == 0) l = f - 2;
        else l = f + $urandom_range(0, 3);
        if (l > 255) l = 255;
        tbl_first[i] = CB'(f);
        tbl_last[i]  = CB'(l);
      end
      rmode = (it % 3 == 0) ? 0 : 2;
      compute_expected(tss);
      start_sweep(tss);
      wait_done(lat);
      compare_sweep();
      post_idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_um_jleugeri_ttt_event_scheduler.md
Name: tt_um_jleugeri_ttt_event_scheduler

Overview:
Sequencer for the token-network update. On each `go_in` pulse it snapshots the per-processor start/stop event flags and scans processors in ascending index order. For every processor with a net event, it fetches that processor's outgoing-connection range from the connection table. It then issues one signed token delta per connection to the downstream accumulator over a valid/ready handshake, and finishes the sweep with a `done_out` pulse.

Parameters:
- NUM_PROCESSORS, 10, number of token processors (≥2)
- IDX_BITS, $clog2(NUM_PROCESSORS), processor index width
- CONN_BITS, 8, connection-table address width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- go_in  in  1  start-sweep request; sampled only in IDLE
- busy_out  out  1  high whenever state ≠ IDLE
- done_out  out  1  single-cycle end-of-sweep pulse
- tstartstop_in  in  2*NUM_PROCESSORS  bit 2i = start of processor i, bit 2i+1 = stop of processor i
- range_req_out  out  1  connection-range lookup strobe, one cycle
- src_idx_out  out  IDX_BITS  processor currently scanned/served
- range_first_in  in  CONN_BITS  first connection address of src; valid one cycle after range_req_out
- range_last_in  in  CONN_BITS  last connection address (inclusive); same timing
- tgt_valid_out  out  1  delta available
- tgt_ready_in  in  1  downstream accepts delta
- conn_addr_out  out  CONN_BITS  connection address of the current delta
- tgt_sign_out  out  1  1 = +1 (start), 0 = −1 (stop)

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0.
  - Pending snapshot, index and connection counters are cleared.
  - Reset mid-sweep abandons the sweep with no `done_out` pulse.
- Net event of processor i is `start − stop`:
  - (1,0) → +1; (0,1) → −1.
  - (1,1) and (0,0) → no event; the processor is skipped.
- States: IDLE, SCAN, FETCH, WAIT, DELIVER, DONE.
- IDLE:
  - On `go_in`=1, latch `tstartstop_in` into the pending register, set idx=0, go to SCAN.
  - `go_in` in any other state is ignored. The input is not re-sampled during a sweep.
- SCAN (one processor per cycle):
  - If pending(idx) is a net event → FETCH.
  - Else if idx = NUM_PROCESSORS−1 → DONE.
  - Else idx+1, stay in SCAN.
- FETCH (1 cycle):
  - `range_req_out`=1 with `src_idx_out`=idx.
  - Latch the sign. Go to WAIT.
- WAIT (1 cycle):
  - Capture `range_first_in` / `range_last_in`.
  - If first > last (empty range), advance as from SCAN: next idx, or DONE if idx was last.
  - Else conn=first → DELIVER.
- DELIVER:
  - `tgt_valid_out`=1; `conn_addr_out`=conn; `tgt_sign_out` = latched sign.
  - Outputs stay stable until `tgt_ready_in`=1 on a clock edge.
  - On acceptance: if conn = last, advance to the next source (or DONE if idx was last); else conn+1.
  - The last-check compares before incrementing, so last = 2^CONN_BITS−1 terminates without wrap.
- Throughput: with `tgt_ready_in` held at 1, one delta is delivered per cycle.
- DONE (1 cycle): `done_out`=1, then IDLE. `busy_out` stays 1 during DONE.
- Latency: with no events, `go_in` is sampled at edge k, SCAN runs cycles k+1..k+N, and `done_out` is high in cycle k+N+1.
- `src_idx_out` holds idx in all non-IDLE states and is 0 in IDLE.
- `range_req_out`, `tgt_valid_out` and `done_out` are mutually exclusive.

Test Plan:
- No events, N=10, go pulse → 10 SCAN cycles, no `range_req_out` and no `tgt_valid_out`, `done_out` exactly 11 cycles after go is sampled, `busy_out` high 11 cycles.
- Processor 3 start only, range 5..7, ready=1 → one `range_req_out` with src=3, then conn_addr 5, 6, 7 with sign=1 on consecutive cycles, then `done_out`.
- Processor 0 stop, processor 9 start; ready toggling 1-0-1 → processor 0's deltas carry sign=0 and processor 9's carry sign=1. Outputs stay stable while ready=0, and no delta is duplicated or dropped.
- Processor 4 with start and stop both set, processor 6 with range first=8, last=2 → neither issues a delta; processor 4 is never looked up; `done_out` still occurs.
- Range 254..255 with CONN_BITS=8 → exactly two deltas (254, 255), no wrap to 0. Changing `tstartstop_in` or pulsing `go_in` mid-sweep has no effect.
- rst_n asserted during DELIVER → all outputs 0 immediately; no `done_out`; a fresh go after release runs a complete sweep.
